// File: rtl/traffic_light_fsm_if.sv
// Control and status bundle between the traffic-light sequencer and its user.
// The LED colour stage and the pedestrian panel sit on the master side.
interface traffic_light_fsm_if;
  logic       enable;
  logic       ped_req;
  logic [1:0] color;
  logic [3:0] sec_left;
  logic       ped_walk;
  logic       ped_pending;
  logic       phase_start;

  modport master (
    output enable, ped_req,
    input  color, sec_left, ped_walk, ped_pending, phase_start
  );

  modport slave (
    input  enable, ped_req,
    output color, sec_left, ped_walk, ped_pending, phase_start
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// Timed RED -> GREEN -> YELLOW sequencer with a one-second prescaler,
// pedestrian early exit from GREEN, and forced OFF while disabled.
module traffic_light_fsm #(
  parameter int unsigned TICK_DIV      = 100000000,
  parameter int unsigned RED_SEC       = 5,
  parameter int unsigned GREEN_SEC     = 5,
  parameter int unsigned YELLOW_SEC    = 2,
  parameter int unsigned MIN_GREEN_SEC = 2
) (
  input  logic                clk,
  input  logic                rst,
  traffic_light_fsm_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [3:0]    RED_DUR    = 4'(RED_SEC);
  localparam logic [3:0]    GREEN_DUR  = 4'(GREEN_SEC);
  localparam logic [3:0]    YELLOW_DUR = 4'(YELLOW_SEC);
  localparam logic [4:0]    GREEN_DUR5 = 5'(GREEN_SEC);
  localparam logic [4:0]    MIN_GREEN5 = 5'(MIN_GREEN_SEC);

  localparam logic [1:0] COL_RED    = 2'd0;
  localparam logic [1:0] COL_YELLOW = 2'd1;
  localparam logic [1:0] COL_GREEN  = 2'd2;
  localparam logic [1:0] COL_OFF    = 2'd3;

  typedef enum logic [1:0] {ST_OFF, ST_RED, ST_GREEN, ST_YELLOW} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_q, sec_d;
  logic          pend_q, pend_d;
  logic          start_q, start_d;
  logic [1:0]    color_q, color_d;
  logic          walk_q, walk_d;

  logic          tick;
  logic          pend_now;
  logic          min_green_met;
  logic [4:0]    green_elapsed;
  logic          entry;

  assign tick          = (state_q != ST_OFF) && (presc_q == TICK_LAST);
  assign pend_now      = pend_q | bus.ped_req;
  // Seconds of GREEN already shown, including the one ending on this tick.
  assign green_elapsed = GREEN_DUR5 - {1'b0, sec_q} + 5'd1;
  assign min_green_met = (green_elapsed >= MIN_GREEN5);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      presc_q <= '0;
      sec_q   <= '0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      color_q <= COL_OFF;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      color_q <= color_d;
      walk_q  <= walk_d;
    end
  end

  // Next-state logic; disable overrides any tick or phase advance.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:    state_d = ST_RED;
        ST_RED:    if (tick && (sec_q == 4'd1)) state_d = ST_GREEN;
        ST_GREEN:  if (tick && ((sec_q == 4'd1) || (pend_now && min_green_met)))
                     state_d = ST_YELLOW;
        ST_YELLOW: if (tick && (sec_q == 4'd1)) state_d = ST_RED;
        default:   state_d = ST_OFF;
      endcase
    end
  end

  // Next values of the timer, pedestrian latch and decoded outputs.
  always_comb begin
    entry   = (state_d != state_q) && (state_d != ST_OFF);
    presc_d = presc_q + PW'(1);
    sec_d   = sec_q;
    pend_d  = pend_q;
    start_d = entry;
    color_d = COL_OFF;
    walk_d  = 1'b0;

    if (state_d == ST_OFF) begin
      presc_d = '0;
      sec_d   = '0;
      pend_d  = 1'b0;
    end else begin
      if (entry || tick) presc_d = '0;
      if (entry) begin
        case (state_d)
          ST_RED:    sec_d = RED_DUR;
          ST_GREEN:  sec_d = GREEN_DUR;
          ST_YELLOW: sec_d = YELLOW_DUR;
          default:   sec_d = '0;
        endcase
      end else if (tick) begin
        sec_d = sec_q - 4'd1;
      end
      // Entering RED serves the request, even if a new one arrives this cycle.
      if (entry && (state_d == ST_RED)) begin
        pend_d = 1'b0;
      end else if (bus.ped_req && ((state_q == ST_GREEN) || (state_q == ST_YELLOW))) begin
        pend_d = 1'b1;
      end
    end

    case (state_d)
      ST_RED: begin
        color_d = COL_RED;
        walk_d  = 1'b1;
      end
      ST_GREEN:  color_d = COL_GREEN;
      ST_YELLOW: color_d = COL_YELLOW;
      default:   color_d = COL_OFF;
    endcase
  end

  assign bus.color       = color_q;
  assign bus.sec_left    = sec_q;
  assign bus.ped_walk    = walk_q;
  assign bus.ped_pending = pend_q;
  assign bus.phase_start = start_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: directed scenarios plus random pedestrian and
// enable traffic, checked against a cycle-counting model of the light.
module tb_traffic_light_fsm;

  localparam int TD = 4;
  localparam int RS = 3;
  localparam int GS = 4;
  localparam int YS = 1;
  localparam int MG = 2;
  localparam logic [8:0] RESET_VEC = {2'd3, 4'd0, 3'b000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_light_fsm_if bus();

  traffic_light_fsm #(
    .TICK_DIV(TD), .RED_SEC(RS), .GREEN_SEC(GS),
    .YELLOW_SEC(YS), .MIN_GREEN_SEC(MG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: colour code of the phase and cycles spent in it so far.
  int m_phase;
  int m_cyc;
  bit m_pend;
  bit m_start;

  function automatic int dur(input int ph);
    case (ph)
      0: return RS;
      2: return GS;
      1: return YS;
      default: return 0;
    endcase
  endfunction

  function automatic int nxt(input int ph);
    case (ph)
      0: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_phase = 3;
    m_cyc   = 0;
    m_pend  = 1'b0;
    m_start = 1'b0;
  endfunction

  function automatic void model_update(input bit en, input bit req);
    bit sec_end;
    int done;
    bit adv;
    if (!en) begin
      model_reset();
    end else if (m_phase == 3) begin
      m_phase = 0;
      m_cyc   = 0;
      m_pend  = 1'b0;
      m_start = 1'b1;
    end else begin
      sec_end = ((m_cyc % TD) == TD - 1);
      done    = m_cyc / TD + 1;
      adv     = sec_end && ((done == dur(m_phase)) ||
                (m_phase == 2 && (m_pend || req) && done >= MG));
      if (req && (m_phase == 1 || m_phase == 2)) m_pend = 1'b1;
      if (adv) begin
        m_phase = nxt(m_phase);
        m_cyc   = 0;
        m_start = 1'b1;
        if (m_phase == 0) m_pend = 1'b0;
      end else begin
        m_cyc   = m_cyc + 1;
        m_start = 1'b0;
      end
    end
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [3:0] s;
    s = (m_phase == 3) ? 4'd0 : 4'(dur(m_phase) - m_cyc / TD);
    return {2'(m_phase), s, (m_phase == 0), m_pend, m_start};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {bus.color, bus.sec_left, bus.ped_walk, bus.ped_pending, bus.phase_start};
  endfunction

  // One clock: drive inputs at negedge, advance model at posedge, return at negedge.
  task automatic step(input bit en, input bit req);
    bus.enable  = en;
    bus.ped_req = req;
    @(posedge clk);
    model_update(en, req);
    @(negedge clk);
  endtask

  task automatic wait_entry(input int col, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sync_model t=%0t: got %b expected %b", $time, obs_vec(), exp_vec());
      end
      if (bus.phase_start && bus.color == 2'(col)) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sync_timeout: colour %0d entry not seen within 80 cycles", col);
    end
  endtask

  task automatic test_reset();
    bus.enable  = 1'b0;
    bus.ped_req = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected %b", obs_vec(), RESET_VEC);
    end
    bus.enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_over_enable: got %b expected %b", obs_vec(), RESET_VEC);
    end
  endtask

  task automatic test_sequence();
    int n_red, n_green, n_yellow, n_start;
    n_red = 0; n_green = 0; n_yellow = 0; n_start = 0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL seq_model cyc=%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (i == 0 && bus.color !== 2'd0) begin
        n_fail++;
        $display("FAIL seq_first_red: got %0d expected 0", bus.color);
      end
      if (bus.color == 2'd0) n_red++;
      if (bus.color == 2'd2) n_green++;
      if (bus.color == 2'd1) n_yellow++;
      if (bus.phase_start) n_start++;
    end
    n_cmp++;
    if (n_red != 12 || n_green != 16 || n_yellow != 4 || n_start != 3) begin
      n_fail++;
      $display("FAIL seq_lengths: got r=%0d g=%0d y=%0d starts=%0d expected 12 16 4 3",
               n_red, n_green, n_yellow, n_start);
    end
  endtask

  task automatic test_ped_early();
    bit ok;
    int glen;
    wait_entry(2, ok);
    glen = 1;
    for (int k = 1; k < 40; k++) begin
      step(1'b1, k == 2);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL early_model k=%0d: got %b expected %b", k, obs_vec(), exp_vec());
      end
      if (bus.color != 2'd2) break;
      glen++;
    end
    n_cmp++;
    if (glen != 8) begin
      n_fail++;
      $display("FAIL early_green_len: got %0d expected 8", glen);
    end
    wait_entry(0, ok);
    n_cmp++;
    if (bus.ped_pending !== 1'b0 || bus.ped_walk !== 1'b1) begin
      n_fail++;
      $display("FAIL early_red_entry: got pend=%b walk=%b expected 0 1",
               bus.ped_pending, bus.ped_walk);
    end
  endtask

  task automatic test_ped_late();
    bit ok;
    int glen;
    wait_entry(2, ok);
    glen = 1;
    for (int k = 1; k < 40; k++) begin
      step(1'b1, k == 15);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL late_model k=%0d: got %b expected %b", k, obs_vec(), exp_vec());
      end
      if (bus.color != 2'd2) break;
      glen++;
    end
    n_cmp++;
    if (glen != 16 || bus.ped_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL late_green: got len=%0d pend=%b expected 16 1", glen, bus.ped_pending);
    end
    wait_entry(0, ok);
    n_cmp++;
    if (bus.ped_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL late_red_clear: got %b expected 0", bus.ped_pending);
    end
  endtask

  task automatic test_ped_hold();
    bit ok;
    bit red_pend;
    int glen;
    wait_entry(0, ok);
    red_pend = 1'b0;
    glen = 0;
    for (int k = 0; k < 60; k++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL hold_model k=%0d: got %b expected %b", k, obs_vec(), exp_vec());
      end
      if (bus.color == 2'd0 && bus.ped_pending) red_pend = 1'b1;
      if (bus.color == 2'd2) glen++;
      else if (glen != 0) break;
    end
    n_cmp++;
    if (red_pend || glen != 8) begin
      n_fail++;
      $display("FAIL hold_result: got red_pend=%b glen=%0d expected 0 8", red_pend, glen);
    end
    bus.ped_req = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit ok;
    wait_entry(2, ok);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_cmp++;
    if (bus.sec_left !== 4'd3 || bus.ped_pending !== 1'b1 || bus.color !== 2'd2) begin
      n_fail++;
      $display("FAIL drop_pre: got col=%0d sec=%0d pend=%b expected 2 3 1",
               bus.color, bus.sec_left, bus.ped_pending);
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (bus.color !== 2'd3 || bus.sec_left !== 4'd0 || bus.ped_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_off: got col=%0d sec=%0d pend=%b expected 3 0 0",
               bus.color, bus.sec_left, bus.ped_pending);
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if (bus.color !== 2'd0 || bus.sec_left !== 4'd3 || bus.phase_start !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_restart: got col=%0d sec=%0d start=%b expected 0 3 1",
               bus.color, bus.sec_left, bus.phase_start);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int rlen;
    wait_entry(1, ok);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", obs_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    rlen = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_model k=%0d: got %b expected %b", k, obs_vec(), exp_vec());
      end
      if (bus.color == 2'd0) rlen++;
      else break;
    end
    n_cmp++;
    if (rlen != 12) begin
      n_fail++;
      $display("FAIL rst_red_len: got %0d expected 12", rlen);
    end
  endtask

  task automatic test_random();
    bit en, req;
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom % 40) != 0;
      req = ($urandom % 6) == 0;
      step(en, req);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model i=%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ped_early();
    test_ped_late();
    test_ped_hold();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Timed traffic-light sequencer that produces the 2-bit colour code consumed by the RGB LED PWM colour stage.
- Colour encoding: RED=0, YELLOW=1, GREEN=2, OFF=3.
- Cycles RED -> GREEN -> YELLOW -> RED using per-phase durations counted in seconds from a clock prescaler.
- Supports a pedestrian request that shortens GREEN, and an enable input that forces OFF.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second tick; legal range >= 2.
- RED_SEC, 5: RED duration in seconds; legal range 1..15.
- GREEN_SEC, 5: GREEN duration in seconds; legal range 1..15.
- YELLOW_SEC, 2: YELLOW duration in seconds; legal range 1..15.
- MIN_GREEN_SEC, 2: minimum GREEN seconds before a pedestrian request may end GREEN; legal range 1..GREEN_SEC.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  1 = run the sequence; 0 = force OFF.
- ped_req  input  1  pedestrian request, level or pulse, synchronous to clk.
- color  output  2  colour code to the LED stage (0 RED, 1 YELLOW, 2 GREEN, 3 OFF).
- sec_left  output  4  seconds remaining in the current phase; 0 in OFF.
- ped_walk  output  1  high while in RED.
- ped_pending  output  1  latched pedestrian request, not yet served.
- phase_start  output  1  one-cycle pulse in the first cycle of each new RED, GREEN or YELLOW phase.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values (async, immediate): state=OFF, color=3, sec_left=0, ped_walk=0, ped_pending=0, phase_start=0, prescaler=0.
- All outputs are registered. color, sec_left and ped_walk are decoded from the state register and timer, with no extra latency.
- States: OFF, RED, GREEN, YELLOW.
- OFF: if enable=1, the next clk enters RED. Otherwise remain in OFF.
- Any state with enable=0: the next clk enters OFF. In that same cycle sec_left -> 0, ped_pending -> 0 and prescaler -> 0.
- Phase entry, in the same clock edge as the state change:
  - sec_left <- phase duration (RED_SEC, GREEN_SEC or YELLOW_SEC).
  - prescaler <- 0.
  - phase_start <- 1 for exactly one cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 while in RED, GREEN or YELLOW.
  - tick is an internal strobe asserted when prescaler == TICK_DIV-1.
  - On tick the prescaler wraps to 0.
  - Counter width is $clog2(TICK_DIV).
- On tick with s = sec_left (value before update):
  - If s == 1: advance to the next phase. RED -> GREEN, GREEN -> YELLOW, YELLOW -> RED.
  - Otherwise: sec_left <- s - 1 and stay in the phase.
- Resulting phase length: exactly DUR*TICK_DIV clk cycles, with sec_left counting DUR, DUR-1, ..., 1.
- Pedestrian early exit:
  - In GREEN on tick, define pend = ped_pending | ped_req.
  - If pend=1 and (GREEN_SEC - s + 1) >= MIN_GREEN_SEC, go to YELLOW, even if s > 1.
- ped_pending rules:
  - Set when ped_req=1 in GREEN or YELLOW.
  - Cleared on entry to RED.
  - ped_req during RED or OFF is ignored and not latched. A walk is already active in RED; the system is dark in OFF.
  - Simultaneous ped_req and RED entry: the clear wins.
- Simultaneous events:
  - enable=0 has priority over tick and over phase advance.
  - rst has priority over everything.
- Reset mid-phase: immediate return to OFF with all reset values. A new sequence starts at RED with the full RED_SEC.
- enable re-asserted: the sequence always restarts at RED with the full RED_SEC; the previous phase is not resumed.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, RED_SEC=3, GREEN_SEC=4, YELLOW_SEC=1, MIN_GREEN_SEC=2.
1. Release rst with enable=1 -> color goes 3 -> 0 one clk later. Then RED lasts 12 cycles, GREEN 16 cycles, YELLOW 4 cycles, then RED again (period 32 cycles). sec_left during RED steps 3, 2, 1 every 4 cycles. phase_start pulses once at each entry.
2. Pulse ped_req for 1 cycle at GREEN cycle 1 -> ped_pending=1. At the 2nd GREEN tick (GREEN cycle 8) color becomes 1, so GREEN lasts 8 cycles. On RED entry ped_pending returns to 0 and ped_walk=1.
3. Pulse ped_req at GREEN cycle 14 (sec_left=1) -> GREEN still lasts its normal 16 cycles. ped_pending stays 1 through YELLOW and clears on RED entry.
4. ped_req held high through all of RED -> ped_pending stays 0. Entering GREEN with ped_req still high -> GREEN ends after 8 cycles (MIN_GREEN_SEC reached).
5. Drop enable mid-GREEN with sec_left=3 -> next clk color=3, sec_left=0, ped_pending=0. Re-raise enable -> next clk color=0, sec_left=3, phase_start=1.
6. Assert rst asynchronously between clk edges mid-YELLOW -> outputs reach their reset values before the next clk edge. After release with enable=1, RED lasts its full 12 cycles.
